mem_stage: RTL

- Consumer end of the EX/MEM pipeline interface.
- Takes the EX/MEM register outputs (ALU result, store data, control bits) and services loads and stores against a multi-cycle data memory using a request/done handshake.
- Stalls upstream stages while an access is outstanding.
- Loads the MEM/WB pipeline register, passing through register-writeback, halt and branch/PC information.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_hold_reg.sv | 37 +++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and the
// MEM/WB control bundle together with its bubble value.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Control bits that travel from EX/MEM into MEM/WB
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic halt;
      logic dump;
      logic take_branch;
   } wb_ctrl_t;

   // A bubble must never write a register, halt, dump or redirect the PC
   localparam wb_ctrl_t WB_BUBBLE = '{default: 1'b0};

endpackage

// File: rtl/mem_stage_hold_reg.sv
// Hold registers for an outstanding memory access. Loaded once when the
// request launches, then they are the only source of address, data and
// writeback information until the access completes.
module mem_hold_reg
   import mem_stage_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          en,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic [DW-1:0] pcs,
   input  logic [2:0]    wr_reg,
   input  logic          is_load,
   input  wb_ctrl_t      ctrl,
   output logic [DW-1:0] held_addr,
   output logic [DW-1:0] held_wdata,
   output logic [DW-1:0] held_pcs,
   output logic [2:0]    held_wr_reg,
   output logic          held_is_load,
   output wb_ctrl_t      held_ctrl
);

   // Capture the access operands on request launch; hold them otherwise
   always_ff @(posedge clk) begin
      if (en) begin
         held_addr    <= addr;
         held_wdata   <= wdata;
         held_pcs     <= pcs;
         held_wr_reg  <= wr_reg;
         held_is_load <= is_load;
         held_ctrl    <= ctrl;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: services loads/stores against a multi-cycle data
// memory with a request/done handshake, stalls upstream while an access is
// outstanding, and loads the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] ALUO_EXMEM,
   input  logic [DW-1:0] Rd2_EXMEM,
   input  logic [DW-1:0] PCS_EXMEM,
   input  logic [2:0]    WrR_EXMEM,
   input  logic          RegWrite_EXMEM,
   input  logic          MemtoReg_EXMEM,
   input  logic          MemWrite_EXMEM,
   input  logic          MemRead_EXMEM,
   input  logic          Dump_EXMEM,
   input  logic          halt_EXMEM,
   input  logic          takeBranch_EXMEM,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_done,
   input  logic          mem_err,
   output logic          stall,
   output logic [DW-1:0] ALUO_MEMWB,
   output logic [DW-1:0] MemData_MEMWB,
   output logic [DW-1:0] PCS_MEMWB,
   output logic [2:0]    WrR_MEMWB,
   output logic          RegWrite_MEMWB,
   output logic          MemtoReg_MEMWB,
   output logic          halt_MEMWB,
   output logic          Dump_MEMWB,
   output logic          takeBranch_MEMWB,
   output logic          err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          mem_op;
   logic          start;
   logic          bad_op;
   logic          pass;
   logic          finish;
   logic          timeout;
   wb_ctrl_t      ex_ctrl;
   wb_ctrl_t      held_ctrl;
   wb_ctrl_t      ctrl_p1;
   logic [DW-1:0] held_addr;
   logic [DW-1:0] held_wdata;
   logic [DW-1:0] held_pcs;
   logic [2:0]    held_wr_reg;
   logic          held_is_load;

   assign ex_ctrl = '{reg_write:   RegWrite_EXMEM,
                      mem_to_reg:  MemtoReg_EXMEM,
                      halt:        halt_EXMEM,
                      dump:        Dump_EXMEM,
                      take_branch: takeBranch_EXMEM};

   // Requests are suppressed while reset is held so nothing launches then
   assign mem_op  = MemRead_EXMEM | MemWrite_EXMEM;
   assign start   = (state == IDLE) & ~rst & (MemRead_EXMEM ^ MemWrite_EXMEM) & ~ALUO_EXMEM[0];
   assign bad_op  = (state == IDLE) & ~rst &
                    ((MemRead_EXMEM & MemWrite_EXMEM) | (mem_op & ALUO_EXMEM[0]));
   assign pass    = (state == IDLE) & ~mem_op;
   assign finish  = (state == BUSY) & mem_done;
   assign timeout = (state == BUSY) & ~mem_done & (cnt == CW'(TIMEOUT - 1));

   mem_hold_reg #(.DW(DW)) u_hold (
      .clk          (clk),
      .en           (start),
      .addr         (ALUO_EXMEM),
      .wdata        (Rd2_EXMEM),
      .pcs          (PCS_EXMEM),
      .wr_reg       (WrR_EXMEM),
      .is_load      (MemRead_EXMEM),
      .ctrl         (ex_ctrl),
      .held_addr    (held_addr),
      .held_wdata   (held_wdata),
      .held_pcs     (held_pcs),
      .held_wr_reg  (held_wr_reg),
      .held_is_load (held_is_load),
      .held_ctrl    (held_ctrl)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: launch on a valid access, return on done or timeout
   always_comb begin
      state_nxt = state;
      if (state == IDLE) begin
         if (start) state_nxt = BUSY;
      end else begin
         if (mem_done || timeout) state_nxt = IDLE;
      end
   end

   // FSM outputs: request pulse, stall, and address/data to the memory
   always_comb begin
      stall     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == IDLE) begin
         if (start) begin
            stall     = 1'b1;
            mem_rd    = MemRead_EXMEM;
            mem_wr    = MemWrite_EXMEM;
            mem_addr  = ALUO_EXMEM;
            mem_wdata = Rd2_EXMEM;
         end
      end else begin
         // Release the stall on the done cycle so EX/MEM advances with it
         stall     = ~mem_done;
         mem_addr  = held_addr;
         mem_wdata = held_wdata;
      end
   end

   // BUSY cycle counter, cleared whenever idle
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   // Sticky error: bad request, memory fault on completion, or timeout
   always_ff @(posedge clk) begin
      if (rst)                                     err <= 1'b0;
      else if (bad_op || timeout || (finish && mem_err)) err <= 1'b1;
   end

   // ---- MEM/WB boundary: pass-through, completed access, or bubble ----
   always_ff @(posedge clk) begin
      if (rst || !(pass || finish)) begin
         ALUO_MEMWB    <= '0;
         MemData_MEMWB <= '0;
         PCS_MEMWB     <= '0;
         WrR_MEMWB     <= '0;
         ctrl_p1       <= WB_BUBBLE;
      end else if (pass) begin
         ALUO_MEMWB    <= ALUO_EXMEM;
         MemData_MEMWB <= '0;
         PCS_MEMWB     <= PCS_EXMEM;
         WrR_MEMWB     <= WrR_EXMEM;
         ctrl_p1       <= ex_ctrl;
      end else begin
         ALUO_MEMWB    <= held_addr;
         MemData_MEMWB <= held_is_load ? mem_rdata : '0;
         PCS_MEMWB     <= held_pcs;
         WrR_MEMWB     <= held_wr_reg;
         ctrl_p1       <= held_ctrl;
      end
   end

   assign RegWrite_MEMWB   = ctrl_p1.reg_write;
   assign MemtoReg_MEMWB   = ctrl_p1.mem_to_reg;
   assign halt_MEMWB       = ctrl_p1.halt;
   assign Dump_MEMWB       = ctrl_p1.dump;
   assign takeBranch_MEMWB = ctrl_p1.take_branch;

endmodule
